// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op-codes, FSM encoding, op classification.
// No logic of its own; latency and backpressure are properties of the users.
// Codes 0x14..0x1F are left undefined and decode as illegal in the ALU.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_NEG  = 5'h02;
  localparam logic [4:0] ALU_MUL  = 5'h03;
  localparam logic [4:0] ALU_AND  = 5'h04;
  localparam logic [4:0] ALU_OR   = 5'h05;
  localparam logic [4:0] ALU_XOR  = 5'h06;
  localparam logic [4:0] ALU_NOT  = 5'h07;
  localparam logic [4:0] ALU_EQ   = 5'h08;
  localparam logic [4:0] ALU_GT   = 5'h09;
  localparam logic [4:0] ALU_LEQ  = 5'h0A;
  localparam logic [4:0] ALU_NEGI = 5'h0B;
  localparam logic [4:0] ALU_NOTI = 5'h0C;
  localparam logic [4:0] ALU_BZ   = 5'h0D;
  localparam logic [4:0] ALU_BNZ  = 5'h0E;
  localparam logic [4:0] ALU_DIVU = 5'h0F;
  localparam logic [4:0] ALU_REMU = 5'h10;
  localparam logic [4:0] ALU_SHL  = 5'h11;
  localparam logic [4:0] ALU_SHR  = 5'h12;
  localparam logic [4:0] ALU_SAR  = 5'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  // Ops that iterate one bit per cycle (divide by zero is short-circuited by the caller).
  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/iterative_divider.sv
// Unsigned restoring divider producing one quotient bit per step.
// WIDTH steps after load; quotient_o/remainder_o show the values after the current step.
// No backpressure: the owner issues load once, then step every cycle until finished.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  // Partial remainder, dividend/quotient shift register and divisor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// WIDTH-bit stack-CPU ALU with start/done handshake and registered results.
// Single-cycle ops: done one cycle after accept; mul/divu/remu: WIDTH+1 cycles.
// ready low while iterating; start without ready is dropped, never queued.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alu_ctl,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic             branch,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q;
  logic [4:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [WIDTH-1:0] result_q;
  logic             done_q, branch_q, dbz_q, illegal_q;

  logic             accept;
  logic             last_iter;
  logic             div_load;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   cmp_diff;
  logic [WIDTH-1:0] sc_result;
  logic             sc_branch, sc_illegal, sc_dbz;

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = start && ready;
  assign last_iter = (cnt_q == SHW'(WIDTH - 1));
  assign shamt     = operand2[SHW-1:0];
  assign div_load  = accept && is_multicycle(alu_ctl) && (alu_ctl != ALU_MUL) && (operand2 != '0);

  assign done        = done_q;
  assign alu_result  = result_q;
  assign branch      = branch_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = illegal_q;

  // Single-cycle datapath on the live inputs; only captured when the request is accepted.
  always_comb begin
    sc_result  = '0;
    sc_branch  = 1'b0;
    sc_illegal = 1'b0;
    sc_dbz     = 1'b0;
    // Sign-extended difference: its sign is the true signed order, no overflow case.
    cmp_diff   = {operand1[WIDTH-1], operand1} - {operand2[WIDTH-1], operand2};
    case (alu_ctl)
      ALU_ADD:  sc_result = operand1 + operand2;
      ALU_SUB:  sc_result = operand1 - operand2;
      ALU_NEG:  sc_result = '0 - operand1;
      ALU_MUL:  sc_result = '0;
      ALU_AND:  sc_result = operand1 & operand2;
      ALU_OR:   sc_result = operand1 | operand2;
      ALU_XOR:  sc_result = operand1 ^ operand2;
      ALU_NOT:  sc_result = ~operand1;
      ALU_EQ:   sc_result = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
      ALU_GT:   sc_result = {{(WIDTH-1){1'b0}}, (!cmp_diff[WIDTH] && (cmp_diff != '0))};
      ALU_LEQ:  sc_result = {{(WIDTH-1){1'b0}}, (cmp_diff[WIDTH] || (cmp_diff == '0))};
      ALU_NEGI: sc_result = '0 - operand2;
      ALU_NOTI: sc_result = ~operand2;
      ALU_BZ:   sc_branch = (operand2 == '0);
      ALU_BNZ:  sc_branch = (operand2 != '0);
      // Divide ops only reach this path with a zero divisor.
      ALU_DIVU: begin
        sc_result = '1;
        sc_dbz    = 1'b1;
      end
      ALU_REMU: begin
        sc_result = operand1;
        sc_dbz    = 1'b1;
      end
      ALU_SHL:  sc_result = operand1 << shamt;
      ALU_SHR:  sc_result = operand1 >> shamt;
      ALU_SAR:  sc_result = WIDTH'($signed(operand1) >>> shamt);
      default:  sc_illegal = 1'b1;
    endcase
  end

  // Shift-add multiplier step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  iterative_divider #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .reset       (reset),
    .load_i      (div_load),
    .step_i      (state_q == ST_DIV),
    .dividend_i  (operand1),
    .divisor_i   (operand2),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Control FSM with all handshake outputs and the result registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      branch_q  <= 1'b0;
      dbz_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op_q      <= alu_ctl;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            illegal_q <= 1'b0;
            if (alu_ctl == ALU_MUL) begin
              state_q  <= ST_MUL;
              mcand_q  <= operand1;
              mplier_q <= operand2;
              acc_q    <= '0;
            end else if (div_load) begin
              state_q <= ST_DIV;
            end else begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              result_q  <= sc_result;
              branch_q  <= sc_branch;
              dbz_q     <= sc_dbz;
              illegal_q <= sc_illegal;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= acc_d;
            branch_q <= 1'b0;
          end
        end
        ST_DIV: begin
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= (op_q == ALU_REMU) ? div_rem : div_quo;
            branch_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_MUL  = 5'h03;
  localparam logic [4:0] OP_EQ   = 5'h08;
  localparam logic [4:0] OP_GT   = 5'h09;
  localparam logic [4:0] OP_LEQ  = 5'h0A;
  localparam logic [4:0] OP_BZ   = 5'h0D;
  localparam logic [4:0] OP_BNZ  = 5'h0E;
  localparam logic [4:0] OP_DIVU = 5'h0F;
  localparam logic [4:0] OP_REMU = 5'h10;
  localparam logic [4:0] OP_SHL  = 5'h11;
  localparam logic [4:0] OP_SHR  = 5'h12;
  localparam logic [4:0] OP_SAR  = 5'h13;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  alu_ctl;
  logic [31:0] operand1, operand2;
  logic        ready, done, branch, div_by_zero, illegal_op;
  logic [31:0] alu_result;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_ctl     (alu_ctl),
    .operand1    (operand1),
    .operand2    (operand2),
    .ready       (ready),
    .done        (done),
    .alu_result  (alu_result),
    .branch      (branch),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  // Present a request before the next edge; return 1 time unit after the accepting edge
  // with scrambled operands, since inputs may change freely after acceptance.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    alu_ctl  = op;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
  endtask

  // Count edges until done is seen, bounded by max_cyc.
  task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; alu_ctl = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, done, branch, div_by_zero, illegal_op} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/done/br/dbz/ill=%b expected 10000",
               {ready, done, branch, div_by_zero, illegal_op});
    end
    n_checks++;
    if (alu_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_result: got %h expected 00000000", alu_result);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'h0) begin
      n_fail++;
      $display("FAIL add_wrap: done=%b result=%h expected done=1 result=00000000", done, alu_result);
    end
    // Second request presented in the very next cycle while ready is still high.
    start = 1'b1; alu_ctl = OP_SUB; operand1 = 32'd5; operand2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL b2b_sub: done=%b result=%h expected done=1 result=fffffffe", done, alu_result);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || alu_result !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL b2b_idle: done=%b result=%h expected done=0 result=fffffffe", done, alu_result);
    end
  endtask

  task automatic test_mul();
    int bad_busy;
    bad_busy = 0;
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0001);
    for (int i = 1; i <= 32; i++) begin
      // A request during the busy window must be dropped.
      if (i == 5) begin
        start = 1'b1; alu_ctl = OP_ADD; operand1 = 32'd1; operand2 = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (i < 32 && (done !== 1'b0 || ready !== 1'b0)) bad_busy++;
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL mul_busy: %0d busy cycles with done/ready wrong, expected 0", bad_busy);
    end
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'h0001_0000) begin
      n_fail++;
      $display("FAIL mul_result: at k+33 done=%b result=%h expected done=1 result=00010000",
               done, alu_result);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_after: done=%b ready=%b expected done=0 ready=1 (dropped start not queued)",
               done, ready);
    end
  endtask

  task automatic test_div();
    int  cyc;
    bit  seen;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(40, cyc, seen);
    n_checks++;
    if (!seen || cyc != 32 || alu_result !== 32'd14 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_100_7: seen=%b edges=%0d result=%h dbz=%b expected seen=1 edges=32 result=0000000e dbz=0",
               seen, cyc, alu_result, div_by_zero);
    end
    issue(OP_REMU, 32'd100, 32'd7);
    wait_done(40, cyc, seen);
    n_checks++;
    if (!seen || cyc != 32 || alu_result !== 32'd2) begin
      n_fail++;
      $display("FAIL remu_100_7: seen=%b edges=%0d result=%h expected seen=1 edges=32 result=00000002",
               seen, cyc, alu_result);
    end
    issue(OP_DIVU, 32'd5, 32'd0);
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL divu_by_zero: done=%b result=%h dbz=%b expected done=1 result=ffffffff dbz=1",
               done, alu_result, div_by_zero);
    end
    issue(OP_REMU, 32'd9, 32'd0);
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'd9 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL remu_by_zero: done=%b result=%h dbz=%b expected done=1 result=00000009 dbz=1",
               done, alu_result, div_by_zero);
    end
  endtask

  task automatic test_compare_shift();
    issue(OP_GT, 32'h7FFF_FFFF, 32'h8000_0000);
    n_checks++;
    if (alu_result !== 32'd1 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL gt_extreme: result=%h dbz=%b expected 00000001 dbz=0", alu_result, div_by_zero);
    end
    issue(OP_LEQ, 32'h7FFF_FFFF, 32'h8000_0000);
    n_checks++;
    if (alu_result !== 32'd0) begin
      n_fail++;
      $display("FAIL leq_extreme: result=%h expected 00000000", alu_result);
    end
    issue(OP_LEQ, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    n_checks++;
    if (alu_result !== 32'd1) begin
      n_fail++;
      $display("FAIL leq_equal: result=%h expected 00000001", alu_result);
    end
    issue(OP_EQ, 32'h1234_5678, 32'h1234_5678);
    n_checks++;
    if (alu_result !== 32'd1) begin
      n_fail++;
      $display("FAIL eq_same: result=%h expected 00000001", alu_result);
    end
    issue(OP_SAR, 32'h8000_0000, 32'd35);
    n_checks++;
    if (alu_result !== 32'hF000_0000) begin
      n_fail++;
      $display("FAIL sar_35: result=%h expected f0000000", alu_result);
    end
    issue(OP_SHR, 32'h8000_0000, 32'd35);
    n_checks++;
    if (alu_result !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL shr_35: result=%h expected 10000000", alu_result);
    end
    issue(OP_SHL, 32'h0000_0001, 32'd35);
    n_checks++;
    if (alu_result !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL shl_35: result=%h expected 00000008", alu_result);
    end
  endtask

  task automatic test_branch_illegal();
    issue(OP_BZ, 32'd3, 32'd0);
    n_checks++;
    if (branch !== 1'b1 || alu_result !== 32'd0) begin
      n_fail++;
      $display("FAIL bz_zero: branch=%b result=%h expected branch=1 result=00000000", branch, alu_result);
    end
    issue(OP_BNZ, 32'd3, 32'd0);
    n_checks++;
    if (branch !== 1'b0) begin
      n_fail++;
      $display("FAIL bnz_zero: branch=%b expected 0", branch);
    end
    issue(OP_BNZ, 32'd3, 32'd5);
    n_checks++;
    if (branch !== 1'b1) begin
      n_fail++;
      $display("FAIL bnz_nonzero: branch=%b expected 1", branch);
    end
    issue(5'h1F, 32'd11, 32'd22);
    n_checks++;
    if (done !== 1'b1 || alu_result !== 32'd0 || illegal_op !== 1'b1 || branch !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_1f: done=%b result=%h ill=%b br=%b expected done=1 result=00000000 ill=1 br=0",
               done, alu_result, illegal_op, branch);
    end
    issue(OP_ADD, 32'd1, 32'd2);
    n_checks++;
    if (illegal_op !== 1'b0 || alu_result !== 32'd3) begin
      n_fail++;
      $display("FAIL illegal_clear: ill=%b result=%h expected ill=0 result=00000003", illegal_op, alu_result);
    end
  endtask

  task automatic test_reset_mid_mul();
    int done_seen;
    done_seen = 0;
    issue(OP_MUL, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (done !== 1'b0 || alu_result !== 32'h0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_mul: done=%b result=%h ready=%b expected done=0 result=00000000 ready=1",
               done, alu_result, ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || ready !== 1'b1 || alu_result !== 32'h0) begin
      n_fail++;
      $display("FAIL mul_aborted: done pulses=%0d ready=%b result=%h expected 0 pulses ready=1 result=00000000",
               done_seen, ready, alu_result);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_compare_shift();
    test_branch_illegal();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised next-generation ALU for the stack CPU datapath: a WIDTH-bit arithmetic/logic unit with a start/done handshake, registered results, iterative multiply and unsigned divide/remainder, and barrel shifts. Single-cycle operations complete one cycle after acceptance; multiply and divide take WIDTH+1 cycles. It sits between the operand stack read ports and the stack write-back and PC-select logic, and the control unit stalls on `ready`.

## Interface
- `WIDTH`, 32, datapath width; power of two, 8..64.
- `SHW`, $clog2(WIDTH), shift-amount width (derived, not overridden).
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request; accepted when `start && ready`.
- `alu_ctl`  in  5  operation code, sampled on acceptance.
- `operand1`  in  WIDTH  first operand, sampled on acceptance.
- `operand2`  in  WIDTH  second operand, sampled on acceptance.
- `ready`  out  1  unit can accept a request this cycle.
- `done`  out  1  one-cycle pulse: `alu_result`/`branch`/flags are valid.
- `alu_result`  out  WIDTH  registered result, held until next `done`.
- `branch`  out  1  registered branch decision, held until next `done`.
- `div_by_zero`  out  1  set with `done` for divu/remu when operand2==0.
- `illegal_op`  out  1  set with `done` for undefined codes.

## Operation
- Codes 0x00..0x0E: add, sub, neg (0−op1), mul, and, or, xor, not(op1), eq, gt, leq, negi (0−op2), noti(~op2), branch_zero, branch_nzero. New: 0x0F divu, 0x10 remu, 0x11 shl, 0x12 shr (logical), 0x13 sar. 0x14..0x1F illegal.
- Arithmetic modulo 2^WIDTH; no carry/overflow outputs.
- eq/gt/leq: true signed two's-complement compares (op1==op2, op1>op2, op1<=op2); result 1 or 0 zero-extended. Sign derived from a WIDTH+1-bit difference, so no overflow error.
- mul: low WIDTH bits of product, shift-add, one multiplier bit per cycle.
- divu/remu: restoring division, one quotient bit per cycle; shared sub-module. op2==0 → quotient all-ones, remainder = op1, `div_by_zero`=1.
- Shifts use op2[SHW-1:0]; upper bits ignored. sar replicates op1[WIDTH-1].
- branch_zero: `branch`=(op2==0); branch_nzero: `branch`=(op2!=0); result 0. All other codes: `branch`=0.
- illegal: result 0, `illegal_op`=1, branch 0.
- FSM: IDLE, MUL, DIV, DONE.
  - IDLE/DONE + accepted single-cycle op → DONE (result computed from sampled operands).
  - IDLE/DONE + accepted mul → MUL; divu/remu with op2!=0 → DIV; divu/remu with op2==0 → DONE directly.
  - MUL/DIV: count WIDTH iterations, then → DONE.
  - DONE, no accept → IDLE.
- `ready` = state is IDLE or DONE (back-to-back single-cycle ops at full rate). `start` while not ready is ignored, not queued.
- `div_by_zero`/`illegal_op` valid only with `done`; cleared on next acceptance.

## Timing
- Reset (async assert, sync release): state IDLE, `ready`=1, `done`=0, `alu_result`=0, `branch`=0, `div_by_zero`=0, `illegal_op`=0, counters/operand regs 0.
- Accept at edge k: single-cycle op/illegal/div-by-zero → `done` high cycle k+1.
- mul/divu/remu (op2!=0) → `done` high cycle k+WIDTH+1; `ready`=0 cycles k+1..k+WIDTH.
- Operand inputs may change freely after acceptance.
- `done` never high two cycles running for one request; consecutive `done` pulses only for back-to-back accepted single-cycle ops.
- Reset mid-MUL/DIV: operation aborted, no `done`, outputs to reset values.

## Structure
- Package `alu_pkg`: 5-bit op-code localparams (ALU_ADD..ALU_SAR), FSM state encoding, helper `is_multicycle(op)`.
- Sub-module `iterative_divider` (WIDTH-parameterised restoring divider with load/step/quotient/remainder); multiplier, shifter, compares inline.

## Test plan
- Reset mid-mul (start mul 7×9, assert reset at cycle 5) → no `done`, `alu_result`=0, `ready`=1 after release.
- WIDTH=32: add 0xFFFFFFFF+1 → done at k+1, result 0; back-to-back sub 5−7 next cycle → 0xFFFFFFFE, consecutive `done`.
- mul 0x10000×0x10001 → done exactly at k+33, result 0x00010000 (low bits); `start` during busy ignored.
- divu 100/7 → 14; remu 100/7 → 2, each at k+33; divu 5/0 → k+1, 0xFFFFFFFF, `div_by_zero`=1.
- gt 0x7FFFFFFF vs 0x80000000 → 1; leq same → 0; sar 0x80000000 by 35 → 0xF0000000 (amount 3).
- branch_zero op2=0 → `branch`=1; branch_nzero op2=0 → 0; code 0x1F → result 0, `illegal_op`=1.
